// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stage-enable / flush sequencer for the 16-bit five-stage core.
//               Handles load-use bubbles, taken-branch wrong-path flushes and
//               RAM wait-state freezes with timeout, and keeps saturating
//               stall / flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_instr,
    input  logic             ex_valid,
    input  logic             ex_is_lw,
    input  logic [2:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    localparam logic [1:0]       c_REM_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0]       c_TIMEOUT  = 8'(MEM_TIMEOUT);
    localparam logic [7:0]       c_TMR_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_rem;
    logic [7:0]       r_timer;
    logic             r_ret_flush;
    logic             r_lu_hold;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // ID-stage register usage decode
    logic [3:0] w_op;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic       w_reads_rs;
    logic       w_reads_rt;
    logic       w_unused_instr;

    assign w_op           = id_instr[15:12];
    assign w_rs           = id_instr[11:9];
    assign w_rt           = id_instr[8:6];
    assign w_unused_instr = ^id_instr[5:0];

    // sw reads rt too, but that operand is forwarded straight to RAM
    assign w_reads_rs = (w_op == 4'd0) | (w_op == 4'd4) | (w_op == 4'd5) | (w_op == 4'd6);
    assign w_reads_rt = (w_op == 4'd0) | (w_op == 4'd1) | (w_op == 4'd3) | (w_op == 4'd6);

    logic w_mem_stall;
    logic w_branch;
    logic w_load_use;
    logic w_release;
    logic w_eval_flush;
    logic w_check_mem;

    assign w_mem_stall = mem_req & ~mem_ready;
    assign w_branch    = branch_taken & ex_valid;
    // r_lu_hold guarantees exactly one bubble per load-use hazard
    assign w_load_use  = ex_valid & ex_is_lw & ~r_lu_hold &
                         ((w_reads_rs & (w_rs == ex_rd)) | (w_reads_rt & (w_rt == ex_rd)));
    assign w_release    = (r_state == S_MEM_WAIT) & mem_ready;
    assign w_eval_flush = (r_state == S_FLUSH) | (w_release & r_ret_flush);
    assign w_check_mem  = (r_state == S_RUN) | (r_state == S_FLUSH);

    logic       w_pc_en;
    logic       w_if_id_en;
    logic       w_if_id_flush;
    logic       w_id_ex_en;
    logic       w_id_ex_bubble;
    logic       w_ex_mem_en;
    state_t     w_next_state;
    logic [1:0] w_next_rem;
    logic [7:0] w_next_timer;
    logic [7:0] w_timer_inc;
    logic       w_next_ret_flush;
    logic       w_branch_acc;
    logic       w_lu_stall;
    logic       w_err_set;

    assign w_timer_inc = r_timer + c_TMR_ONE;

    // Hazard priority resolution: stage controls and next sequencer state
    always_comb begin
        w_pc_en          = 1'b0;
        w_if_id_en       = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_ex_en       = 1'b0;
        w_id_ex_bubble   = 1'b0;
        w_ex_mem_en      = 1'b0;
        w_next_state     = r_state;
        w_next_rem       = r_rem;
        w_next_timer     = r_timer;
        w_next_ret_flush = r_ret_flush;
        w_branch_acc     = 1'b0;
        w_lu_stall       = 1'b0;
        w_err_set        = 1'b0;

        if (r_state == S_ERR) begin
            w_next_state = S_ERR;
        end else if ((r_state == S_MEM_WAIT) && !mem_ready) begin
            w_next_timer = w_timer_inc;
            if (w_timer_inc == c_TIMEOUT) begin
                w_next_state = S_ERR;
                w_err_set    = 1'b1;
            end
        end else if (w_check_mem && w_mem_stall) begin
            // Freeze; the flush remainder stays parked in r_rem
            w_next_state     = S_MEM_WAIT;
            w_next_timer     = c_TMR_ONE;
            w_next_ret_flush = (r_state == S_FLUSH);
        end else begin
            // RUN / FLUSH behaviour, also used for the MEM_WAIT release cycle
            w_pc_en       = 1'b1;
            w_if_id_en    = 1'b1;
            w_id_ex_en    = 1'b1;
            w_ex_mem_en   = 1'b1;
            w_if_id_flush = w_eval_flush;
            if (w_branch) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_branch_acc   = 1'b1;
                w_next_rem     = c_REM_INIT;
                w_next_state   = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
            end else if (w_eval_flush) begin
                // ID holds a NOP here, so load-use is not considered
                if (r_rem <= 2'd1) begin
                    w_next_rem   = 2'd0;
                    w_next_state = S_RUN;
                end else begin
                    w_next_rem   = r_rem - 2'd1;
                    w_next_state = S_FLUSH;
                end
            end else if (w_load_use) begin
                w_pc_en        = 1'b0;
                w_if_id_en     = 1'b0;
                w_id_ex_bubble = 1'b1;
                w_lu_stall     = 1'b1;
                w_next_state   = S_RUN;
            end else begin
                w_next_state = S_RUN;
            end
        end
    end

    // Sequencer state, sticky error flag and saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_rem       <= 2'd0;
            r_timer     <= 8'd0;
            r_ret_flush <= 1'b0;
            r_lu_hold   <= 1'b0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_rem       <= w_next_rem;
            r_timer     <= w_next_timer;
            r_ret_flush <= w_next_ret_flush;
            r_lu_hold   <= w_lu_stall;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if (!w_pc_en && (r_state != S_ERR) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_branch_acc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    // All stage controls are held low while reset is asserted
    assign pc_en        = rst & w_pc_en;
    assign if_id_en     = rst & w_if_id_en;
    assign if_id_flush  = rst & w_if_id_flush;
    assign id_ex_en     = rst & w_id_ex_en;
    assign id_ex_bubble = rst & w_id_ex_bubble;
    assign ex_mem_en    = rst & w_ex_mem_en;
    assign state        = r_state;
    assign mem_err      = r_mem_err;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl. Instance A uses
//               FLUSH_CYCLES=1 / MEM_TIMEOUT=8; instance B uses
//               FLUSH_CYCLES=3 / CNT_W=3 for flush restart and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [15:0] id_instr;
    logic        ex_valid, ex_is_lw, branch_taken, mem_req, mem_ready;
    logic [2:0]  ex_rd;

    logic        a_pc, a_ifid, a_fl, a_idex, a_bub, a_exm, a_err;
    logic [1:0]  a_st;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifid, b_fl, b_idex, b_bub, b_exm, b_err;
    logic [1:0]  b_st;
    logic [2:0]  b_sc, b_fc;

    pipeline_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst_a), .id_instr(id_instr), .ex_valid(ex_valid),
        .ex_is_lw(ex_is_lw), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(a_pc), .if_id_en(a_ifid), .if_id_flush(a_fl), .id_ex_en(a_idex),
        .id_ex_bubble(a_bub), .ex_mem_en(a_exm), .state(a_st), .mem_err(a_err),
        .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(255), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .id_instr(id_instr), .ex_valid(ex_valid),
        .ex_is_lw(ex_is_lw), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(b_pc), .if_id_en(b_ifid), .if_id_flush(b_fl), .id_ex_en(b_idex),
        .id_ex_bubble(b_bub), .ex_mem_en(b_exm), .state(b_st), .mem_err(b_err),
        .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    // Enable vectors: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}
    localparam logic [5:0]  ZR  = 6'b000000;
    localparam logic [5:0]  RN  = 6'b110101;
    localparam logic [5:0]  LU  = 6'b000111;
    localparam logic [5:0]  BR  = 6'b111111;
    localparam logic [5:0]  FL  = 6'b111101;
    localparam logic [15:0] IDL = 16'hF000;

    typedef struct {
        string      name;
        int         sel;
        logic [5:0] en;
        int         st;
        int         er;
        int         sc;
        int         fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare one scoreboard entry per cycle, mid-cycle
    initial begin
        forever begin
            exp_t        e;
            logic [5:0]  act_en;
            logic [1:0]  act_st;
            logic        act_er;
            logic [15:0] act_sc, act_fc;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel == 0) begin
                    act_en = {a_pc, a_ifid, a_fl, a_idex, a_bub, a_exm};
                    act_st = a_st; act_er = a_err; act_sc = a_sc; act_fc = a_fc;
                end else begin
                    act_en = {b_pc, b_ifid, b_fl, b_idex, b_bub, b_exm};
                    act_st = b_st; act_er = b_err;
                    act_sc = {13'd0, b_sc}; act_fc = {13'd0, b_fc};
                end
                checks++;
                if (act_en !== e.en || act_st !== 2'(e.st) || act_er !== 1'(e.er) ||
                    act_sc !== 16'(e.sc) || act_fc !== 16'(e.fc)) begin
                    errors++;
                    $display("FAIL %s: got en=%b st=%0d err=%b stall=%0d flush=%0d, expected en=%b st=%0d err=%0d stall=%0d flush=%0d",
                             e.name, act_en, act_st, act_er, act_sc, act_fc,
                             e.en, e.st, e.er, e.sc, e.fc);
                end
            end
        end
    end

    task automatic step(input string name, input int sel, input int ra, input int rb,
                        input logic [15:0] instr, input int v, input int lw, input int rd,
                        input int bt, input int mq, input int mr,
                        input logic [5:0] en, input int st, input int er, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a        = ra[0];
        rst_b        = rb[0];
        id_instr     = instr;
        ex_valid     = v[0];
        ex_is_lw     = lw[0];
        ex_rd        = rd[2:0];
        branch_taken = bt[0];
        mem_req      = mq[0];
        mem_ready    = mr[0];
        e.name = name; e.sel = sel; e.en = en; e.st = st; e.er = er; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    task automatic sa(input string name, input int ra, input logic [15:0] instr, input int v,
                      input int lw, input int rd, input int bt, input int mq, input int mr,
                      input logic [5:0] en, input int st, input int er, input int sc, input int fc);
        step(name, 0, ra, 0, instr, v, lw, rd, bt, mq, mr, en, st, er, sc, fc);
    endtask

    task automatic sb(input string name, input int rb, input logic [15:0] instr, input int v,
                      input int lw, input int rd, input int bt, input int mq, input int mr,
                      input logic [5:0] en, input int st, input int er, input int sc, input int fc);
        step(name, 1, 0, rb, instr, v, lw, rd, bt, mq, mr, en, st, er, sc, fc);
    endtask

    initial begin
        int guard;
        rst_a = 1'b0; rst_b = 1'b0; id_instr = IDL; ex_valid = 1'b0; ex_is_lw = 1'b0;
        ex_rd = 3'd0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        // ---- instance A: FLUSH_CYCLES=1, MEM_TIMEOUT=8 ----
        sa("reset",       0, IDL,      0,0,0, 0,0,0, ZR,0,0,0,0);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,0,0);
        sa("lu_stall",    1, 16'h0458, 1,1,2, 0,0,0, LU,0,0,0,0);
        sa("lu_once",     1, 16'h0458, 1,1,2, 0,0,0, RN,0,0,1,0);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,1,0);
        sa("sw_rt",       1, 16'h5280, 1,1,2, 0,0,0, RN,0,0,1,0);
        sa("sw_rs",       1, 16'h5280, 1,1,1, 0,0,0, LU,0,0,1,0);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,2,0);
        sa("addi_rt",     1, 16'h10C0, 1,1,3, 0,0,0, LU,0,0,2,0);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,3,0);
        sa("r0_beq",      1, 16'h6140, 1,1,0, 0,0,0, LU,0,0,3,0);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,4,0);
        sa("no_valid",    1, 16'h6140, 0,1,0, 0,0,0, RN,0,0,4,0);
        sa("op_none",     1, 16'h2000, 1,1,0, 0,0,0, RN,0,0,4,0);
        sa("not_lw",      1, 16'h0458, 1,0,2, 0,0,0, RN,0,0,4,0);
        sa("branch",      1, IDL,      1,0,0, 1,0,0, BR,0,0,4,0);
        sa("after_br",    1, IDL,      0,0,0, 0,0,0, RN,0,0,4,1);
        sa("br_over_lu",  1, 16'h0458, 1,1,2, 1,0,0, BR,0,0,4,1);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,4,2);
        sa("mem_over_br", 1, IDL,      1,0,0, 1,1,0, ZR,0,0,4,2);
        sa("wait1",       1, IDL,      0,0,0, 0,1,0, ZR,2,0,5,2);
        sa("wait2",       1, IDL,      0,0,0, 0,1,0, ZR,2,0,6,2);
        sa("release",     1, IDL,      0,0,0, 0,1,1, RN,2,0,7,2);
        sa("after_rel",   1, IDL,      0,0,0, 0,0,0, RN,0,0,7,2);
        sa("stall_b",     1, IDL,      0,0,0, 0,1,0, ZR,0,0,7,2);
        sa("rel_branch",  1, IDL,      1,0,0, 1,1,1, BR,2,0,8,2);
        sa("after_rb",    1, IDL,      0,0,0, 0,0,0, RN,0,0,8,3);
        sa("stall_c",     1, IDL,      0,0,0, 0,1,0, ZR,0,0,8,3);
        sa("rel_lu",      1, 16'h0458, 1,1,2, 0,1,1, LU,2,0,9,3);
        sa("idle",        1, IDL,      0,0,0, 0,0,0, RN,0,0,10,3);
        sa("to_start",    1, IDL,      0,0,0, 0,1,0, ZR,0,0,10,3);
        for (int i = 0; i < 7; i++)
            sa("to_wait", 1, IDL,      0,0,0, 0,1,0, ZR,2,0,11+i,3);
        sa("to_err",      1, IDL,      0,0,0, 0,1,0, ZR,3,1,18,3);
        sa("err_sticky",  1, IDL,      1,0,0, 1,1,1, ZR,3,1,18,3);
        sa("rst_err",     0, IDL,      0,0,0, 0,0,0, ZR,0,0,0,0);
        sa("idle2",       1, IDL,      0,0,0, 0,0,0, RN,0,0,0,0);
        sa("stall_d",     1, IDL,      0,0,0, 0,1,0, ZR,0,0,0,0);
        sa("wait_d",      1, IDL,      0,0,0, 0,1,0, ZR,2,0,1,0);
        sa("rst_wait",    0, IDL,      0,0,0, 0,1,0, ZR,0,0,0,0);
        sa("post_rst",    1, IDL,      0,0,0, 0,0,0, RN,0,0,0,0);

        // ---- instance B: FLUSH_CYCLES=3, CNT_W=3 ----
        sb("b_reset",     0, IDL,      0,0,0, 0,0,0, ZR,0,0,0,0);
        sb("b_idle",      1, IDL,      0,0,0, 0,0,0, RN,0,0,0,0);
        sb("b_branch",    1, IDL,      1,0,0, 1,0,0, BR,0,0,0,0);
        sb("b_flush1",    1, IDL,      0,0,0, 0,0,0, FL,1,0,0,1);
        sb("flush_lu_ign",1, 16'h0458, 1,1,2, 0,0,0, FL,1,0,0,1);
        sb("flush_done",  1, IDL,      0,0,0, 0,0,0, RN,0,0,0,1);
        sb("b_branch2",   1, IDL,      1,0,0, 1,0,0, BR,0,0,0,1);
        sb("flush_mem",   1, IDL,      0,0,0, 0,1,0, ZR,1,0,0,2);
        sb("rel_flush",   1, IDL,      0,0,0, 0,1,1, FL,2,0,1,2);
        sb("flush_tail",  1, IDL,      0,0,0, 0,0,0, FL,1,0,1,2);
        sb("b_run",       1, IDL,      0,0,0, 0,0,0, RN,0,0,1,2);
        for (int i = 0; i < 9; i++)
            sb("br_restart", 1, IDL,   1,0,0, 1,0,0, BR,(i == 0) ? 0 : 1,0,1,(2 + i > 7) ? 7 : 2 + i);
        sb("fl_a",        1, IDL,      0,0,0, 0,0,0, FL,1,0,1,7);
        sb("fl_b",        1, IDL,      0,0,0, 0,0,0, FL,1,0,1,7);
        sb("fl_end",      1, IDL,      0,0,0, 0,0,0, RN,0,0,1,7);
        sb("b_stall",     1, IDL,      0,0,0, 0,1,0, ZR,0,0,1,7);
        for (int i = 0; i < 8; i++)
            sb("sat_wait", 1, IDL,     0,0,0, 0,1,0, ZR,2,0,(2 + i > 7) ? 7 : 2 + i,7);
        sb("sat_rel",     1, IDL,      0,0,0, 0,1,1, RN,2,0,7,7);
        sb("sat_run",     1, IDL,      0,0,0, 0,0,0, RN,0,0,7,7);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
